// File: rtl/dcsk_tx_ctrl.sv
// DCSK transmit controller: per message bit, sends SF chaotic reference chips,
// then the same SF chips XORed with the bit. Frames are MSG_WIDTH bits, MSB first.
module dcsk_tx_ctrl #(
  parameter int MSG_WIDTH = 8,
  parameter int SF        = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 msg_valid,
  input  logic [MSG_WIDTH-1:0] msg_data,
  output logic                 msg_ready,
  input  logic                 abort,
  input  logic                 chaos_bit,
  output logic                 chaos_en,
  output logic                 tx_chip,
  output logic                 tx_valid,
  output logic                 ref_phase,
  output logic                 busy,
  output logic                 done,
  output logic [1:0]           fsm_state
);

  localparam int CW = (SF > 1) ? $clog2(SF) : 1;
  localparam int BW = (MSG_WIDTH > 1) ? $clog2(MSG_WIDTH) : 1;
  localparam logic [CW-1:0] CHIP_LAST = CW'(SF - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(MSG_WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REF  = 2'd1,
    DATA = 2'd2
  } state_t;

  state_t               state;
  state_t               state_nxt;
  logic [MSG_WIDTH-1:0] msg_sr;
  logic [CW-1:0]        chip_cnt;
  logic [BW-1:0]        bit_cnt;
  logic [SF-1:0]        dly;
  logic [SF-1:0]        dly_nxt;
  logic                 slot_end;
  logic                 frame_end;
  logic                 accept;

  // Handshake: a message transfers on a cycle where msg_valid and msg_ready are
  // both high. msg_ready depends only on state, counters and abort (never on
  // msg_valid); msg_valid without msg_ready is ignored and nothing is buffered.
  assign slot_end  = (chip_cnt == CHIP_LAST);
  assign frame_end = (state == DATA) && slot_end && (bit_cnt == BIT_LAST);
  assign msg_ready = ~abort & ((state == IDLE) | frame_end);
  assign accept    = msg_valid & msg_ready;
  assign busy      = (state != IDLE);
  assign fsm_state = state;

  always_comb begin
    state_nxt = state;
    dly_nxt   = dly;
    chaos_en  = 1'b0;
    tx_chip   = 1'b0;
    tx_valid  = 1'b0;
    ref_phase = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (accept) state_nxt = REF;
      end
      REF: begin
        tx_chip   = chaos_bit;
        chaos_en  = 1'b1;
        ref_phase = 1'b1;
        tx_valid  = 1'b1;
        dly_nxt   = (dly << 1) | SF'(chaos_bit);
        if (slot_end) state_nxt = DATA;
      end
      DATA: begin
        // Rotating keeps the oldest reference chip at the top for each DATA chip
        // and restores the original order by the end of the slot.
        tx_chip  = dly[SF-1] ^ msg_sr[MSG_WIDTH-1];
        tx_valid = 1'b1;
        dly_nxt  = (dly << 1) | SF'(dly[SF-1]);
        if (frame_end) begin
          done      = ~abort;
          state_nxt = accept ? REF : IDLE;
        end else if (slot_end) begin
          state_nxt = REF;
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (abort && (state != IDLE)) state_nxt = IDLE;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      msg_sr   <= '0;
      chip_cnt <= '0;
      bit_cnt  <= '0;
      dly      <= '0;
    end else begin
      state <= state_nxt;
      dly   <= dly_nxt;
      if (accept) begin
        msg_sr   <= msg_data;
        chip_cnt <= '0;
        bit_cnt  <= '0;
      end else if (state != IDLE) begin
        if (slot_end) begin
          chip_cnt <= '0;
          if (state == DATA) begin
            bit_cnt <= (bit_cnt == BIT_LAST) ? '0 : bit_cnt + 1'b1;
            msg_sr  <= msg_sr << 1;
          end
        end else begin
          chip_cnt <= chip_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_dcsk_tx_ctrl.sv
// Bench for dcsk_tx_ctrl: streams messages and compares every chip against a
// frame-level DCSK model built from recorded reference chips.
module tb_dcsk_tx_ctrl;

  localparam int W  = 8;
  localparam int SF = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         msg_valid = 1'b0;
  logic [W-1:0] msg_data = '0;
  logic         msg_ready;
  logic         abort = 1'b0;
  logic         chaos_bit = 1'b0;
  logic         chaos_en, tx_chip, tx_valid, ref_phase, busy, done;
  logic [1:0]   fsm_state;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] stream_q[$];
  int  abort_at = -1;
  int  rst_at = -1;
  bit  fixed_chaos = 1'b0;
  int  n_valid, n_done, n_chaos, n_chaos_bad, n_ready_f0;
  logic fix_pat [4] = '{1'b1, 1'b0, 1'b1, 1'b1};

  dcsk_tx_ctrl #(.MSG_WIDTH(W), .SF(SF)) dut (
    .clk(clk), .rst_n(rst_n), .msg_valid(msg_valid), .msg_data(msg_data),
    .msg_ready(msg_ready), .abort(abort), .chaos_bit(chaos_bit),
    .chaos_en(chaos_en), .tx_chip(tx_chip), .tx_valid(tx_valid),
    .ref_phase(ref_phase), .busy(busy), .done(done), .fsm_state(fsm_state)
  );

  always #5 clk = ~clk;

  // Output vector order: tx_valid tx_chip ref_phase chaos_en busy msg_ready done
  function automatic logic [6:0] outs();
    return {tx_valid, tx_chip, ref_phase, chaos_en, busy, msg_ready, done};
  endfunction

  // Plays stream_q back-to-back (msg_valid held high while more remain).
  task automatic run_stream();
    int n, g;
    bit stop, last, is_ref;
    logic [W-1:0] m;
    logic exp_chip;
    logic refc [SF];
    logic [6:0] exp_o, got_o;
    n = stream_q.size();
    g = 0;
    stop = 1'b0;
    n_valid = 0; n_done = 0; n_chaos = 0; n_chaos_bad = 0; n_ready_f0 = 0;
    @(negedge clk);
    msg_valid = 1'b1; msg_data = stream_q[0]; abort = 1'b0; rst_n = 1'b1;
    #1;
    checks++;
    if ({busy, tx_valid, msg_ready} !== 3'b001) begin
      errors++;
      $display("FAIL accept_cycle got busy/tx_valid/ready=%b exp=001", {busy, tx_valid, msg_ready});
    end
    for (int f = 0; f < n && !stop; f++) begin
      m = stream_q[f];
      for (int b = 0; b < W && !stop; b++) begin
        for (int j = 0; j < 2*SF && !stop; j++) begin
          @(negedge clk);
          last   = (b == W-1) && (j == 2*SF-1);
          is_ref = (j < SF);
          if (is_ref) begin
            chaos_bit = fixed_chaos ? fix_pat[j] : 1'($urandom);
            refc[j] = chaos_bit;
            exp_chip = chaos_bit;
          end else begin
            chaos_bit = 1'($urandom);
            exp_chip = refc[j-SF] ^ m[W-1-b];
          end
          msg_valid = (f + 1 < n);
          msg_data  = msg_valid ? stream_q[f+1] : W'($urandom);
          abort     = (g == abort_at);
          rst_n     = !(g == rst_at);
          #1;
          got_o = outs();
          exp_o = {1'b1, exp_chip, is_ref, is_ref, 1'b1, last & ~abort, last & ~abort};
          if (g != rst_at) begin
            checks++;
            if (got_o !== exp_o) begin
              errors++;
              $display("FAIL chip f=%0d bit=%0d j=%0d got=%b exp=%b", f, b, j, got_o, exp_o);
            end
          end
          n_valid += int'(tx_valid);
          n_done  += int'(done);
          n_chaos += int'(chaos_en);
          n_chaos_bad += int'(chaos_en & ~ref_phase);
          if (f == 0) n_ready_f0 += int'(msg_ready);
          if (abort || !rst_n) stop = 1'b1;
          g++;
        end
      end
    end
    @(negedge clk);
    msg_valid = 1'b0; abort = 1'b0; rst_n = 1'b1;
    #1;
    checks++;
    if (outs() !== 7'b0000010) begin
      errors++;
      $display("FAIL post_frame_idle got=%b exp=0000010", outs());
    end
    abort_at = -1;
    rst_at = -1;
    fixed_chaos = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) begin
      @(negedge clk);
      msg_valid = 1'($urandom); abort = 1'($urandom); chaos_bit = 1'($urandom);
    end
    #1;
    checks++;
    if (outs() !== 7'b0000010 && !abort) begin
      errors++;
      $display("FAIL reset_outputs got=%b exp=0000010", outs());
    end
    @(negedge clk);
    rst_n = 1'b1; msg_valid = 1'b0; abort = 1'b0;
    #1;
    checks++;
    if (outs() !== 7'b0000010) begin
      errors++;
      $display("FAIL reset_release got=%b exp=0000010", outs());
    end
  endtask

  task automatic test_single_frame();
    stream_q = '{8'hA5};
    fixed_chaos = 1'b1;
    run_stream();
    checks++;
    if (n_valid !== 64 || n_done !== 1) begin
      errors++;
      $display("FAIL single_counts got valid=%0d done=%0d exp valid=64 done=1", n_valid, n_done);
    end
    checks++;
    if (n_chaos !== 32 || n_chaos_bad !== 0) begin
      errors++;
      $display("FAIL single_chaos_en got=%0d outside_ref=%0d exp=32 outside_ref=0", n_chaos, n_chaos_bad);
    end
  endtask

  task automatic test_back_to_back();
    stream_q = '{8'hFF, 8'h00};
    run_stream();
    checks++;
    if (n_valid !== 128 || n_done !== 2) begin
      errors++;
      $display("FAIL b2b_counts got valid=%0d done=%0d exp valid=128 done=2", n_valid, n_done);
    end
    checks++;
    if (n_ready_f0 !== 1) begin
      errors++;
      $display("FAIL b2b_ready_pulses got=%0d exp=1", n_ready_f0);
    end
    checks++;
    if (n_chaos !== 64 || n_chaos_bad !== 0) begin
      errors++;
      $display("FAIL b2b_chaos_en got=%0d outside_ref=%0d exp=64 outside_ref=0", n_chaos, n_chaos_bad);
    end
  endtask

  task automatic test_abort_data();
    stream_q = '{W'($urandom)};
    abort_at = 3*2*SF + SF + 1;
    run_stream();
    checks++;
    if (n_done !== 0 || n_valid !== 3*2*SF + SF + 2) begin
      errors++;
      $display("FAIL abort_data got done=%0d valid=%0d exp done=0 valid=%0d", n_done, n_valid, 3*2*SF + SF + 2);
    end
  endtask

  task automatic test_abort_idle();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      msg_valid = 1'b1; abort = 1'b1; msg_data = W'($urandom);
      #1;
      checks++;
      if ({msg_ready, busy, tx_valid} !== 3'b000) begin
        errors++;
        $display("FAIL abort_idle got ready/busy/valid=%b exp=000", {msg_ready, busy, tx_valid});
      end
    end
    @(negedge clk);
    msg_valid = 1'b0; abort = 1'b0;
    #1;
    checks++;
    if (outs() !== 7'b0000010) begin
      errors++;
      $display("FAIL abort_idle_after got=%b exp=0000010", outs());
    end
  endtask

  task automatic test_reset_mid();
    stream_q = '{W'($urandom)};
    rst_at = 19;
    run_stream();
    checks++;
    if (n_done !== 0) begin
      errors++;
      $display("FAIL reset_mid_done got=%0d exp=0", n_done);
    end
    stream_q = '{8'h01};
    run_stream();
    checks++;
    if (n_done !== 1 || n_valid !== 64) begin
      errors++;
      $display("FAIL reset_mid_next got done=%0d valid=%0d exp done=1 valid=64", n_done, n_valid);
    end
  endtask

  task automatic test_random();
    for (int r = 0; r < 4; r++) begin
      stream_q = {};
      for (int k = 0; k < int'($urandom_range(1, 3)); k++) stream_q.push_back(W'($urandom));
      run_stream();
      checks++;
      if (n_done !== stream_q.size() || n_valid !== 64 * stream_q.size()) begin
        errors++;
        $display("FAIL random_counts got done=%0d valid=%0d frames=%0d", n_done, n_valid, stream_q.size());
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_abort_data();
    test_abort_idle();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
